traffic_injector: RTL and testbench
===================================

Name: traffic_injector

Overview:
- Packet source for one router Local input port; the transmit end of the local-port Req/Gnt/Full handshake.
- Builds packets carrying destination, sequence ID and sender ID, and presents them one at a time to the router.
- Paces injection with a programmable gap and stops after a programmable packet count.
- The per-node collector at the destination consumes the PacketID/SenderID fields this block emits.

Parameters:
- routerID, 6'b000_000, {x[2:0],y[2:0]} of the attached router; used to skip self in round-robin.
- ModuleID, 6'b000_000, sender ID placed in PacketOut[5:0].
- dataWidth, 32, packet bus width; must be >= 22.
- dim, 4, mesh dimension; x,y each range 0..dim-1.
- DEST_MODE, 0, 0 = fixed destination FIXED_DEST; 1 = round-robin over all nodes except routerID.
- FIXED_DEST, 6'b000_001, destination used when DEST_MODE=0.
- GAP, 4, minimum idle cycles with ReqDnStr low between packets.
- NUM_PACKETS, 16, packets to send; 0 = unlimited.

Ports:
- clk, input, 1, clock, rising edge.
- reset, input, 1, asynchronous active-high reset.
- Enable, input, 1, allows new packets to start.
- PacketOut, output, dataWidth, packet presented to router Local port.
- ReqDnStr, output, 1, request to router; held until granted.
- DnStrFull, input, 1, router local buffer full; blocks a new request.
- GntDnStr, input, 1, one-cycle grant pulse from router.
- PacketsSent, output, 16, count of granted packets.
- Done, output, 1, sticky; all NUM_PACKETS sent.

Behaviour:
- Packet format:
  - [dataWidth-1:22] = 0.
  - [21:16] = DestID {x,y}.
  - [15:6] = PacketID (10-bit).
  - [5:0] = ModuleID.
- Reset (asynchronous, active-high): PacketOut=0, ReqDnStr=0, PacketsSent=0, Done=0, PacketID=0, gap counter=0, round-robin pointer=first node != routerID (scan order x-major: x=0..dim-1, y=0..dim-1), state=IDLE.
- Reset asserted mid-handshake drops ReqDnStr immediately. The granting side sees no request next cycle; no further action is required.
- FSM states:
  - IDLE:
    - Goes to REQ when Enable=1, Done=0 and DnStrFull=0.
    - In the same edge, loads PacketOut with the current DestID/PacketID and sets ReqDnStr=1.
    - If DnStrFull=1 or Enable=0, stays in IDLE with ReqDnStr=0.
  - REQ:
    - ReqDnStr=1; PacketOut held stable.
    - DnStrFull rising while in REQ does not retract the request.
    - Enable=0 while in REQ does not retract the request.
    - When GntDnStr is sampled 1:
      - ReqDnStr<=0.
      - PacketID<=PacketID+1, wrapping 1023->0.
      - PacketsSent<=PacketsSent+1, saturating at 16'hFFFF.
      - Round-robin pointer advances, skipping routerID and wrapping to the start.
      - Gap counter<=GAP.
      - Next state is GAP.
  - GAP:
    - ReqDnStr=0; PacketOut holds the last packet.
    - Decrements the counter each cycle; goes to IDLE when the counter is 0.
    - Result: ReqDnStr stays low for GAP+1 cycles minimum. With GAP=0 it is low for 1 cycle.
- GntDnStr seen in IDLE or GAP is ignored (spurious grant, no count change).
- Done: set on the edge where PacketsSent becomes NUM_PACKETS (NUM_PACKETS>0); sticky until reset. With Done=1 the FSM stays in IDLE.
- Latency:
  - From IDLE with Full=0, ReqDnStr rises 1 cycle after Enable is sampled high.
  - Minimum request length is 2 cycles (router grants the cycle after it sees Req; the injector sees the grant on the following edge).
- DEST_MODE=1 with dim=1 (no other node): stays IDLE, never requests.

Test Plan:
- Basic send: defaults, Enable=1, Full=0, grant 1 cycle after Req -> PacketOut=32'h0001_0000|{PacketID=0,ModuleID} first; ReqDnStr high 2 cycles, then low 5 cycles; PacketID increments 0,1,2; Done=1 and PacketsSent=16 after the 16th grant; no further Req.
- Backpressure: DnStrFull=1 for 10 cycles from start -> ReqDnStr stays 0. Then Full=1 while Req is high, with grant delayed 6 cycles -> Req and PacketOut unchanged until the grant.
- Round-robin: DEST_MODE=1, routerID=6'b001_001, dim=4, NUM_PACKETS=16 -> DestID sequence 000_000, 000_001, 000_010, 000_011, 001_000, 001_010, ...; 001_001 never appears; 16th DestID = 000_000 (wrapped).
- Wrap and saturate: NUM_PACKETS=0, GAP=0, 1100 packets -> PacketID goes 1023->0; Req low exactly 1 cycle between packets.
- Reset mid-request: assert reset while ReqDnStr=1 -> ReqDnStr=0 in the same cycle (async); PacketsSent=0, PacketID=0. After release, the first packet again has ID 0.
- Spurious grant: pulse GntDnStr during GAP -> PacketsSent unchanged, no state change.

Source files
------------

// File: rtl/traffic_injector_if.sv
// ============================================================================
// traffic_injector_if : local-port Req/Gnt/Full handshake bundle to a router
// Rev 1.0
// ============================================================================
`default_nettype none

interface traffic_injector_if #(
  parameter int dataWidth = 32
);
  logic [dataWidth-1:0] PacketOut;
  logic                 ReqDnStr;
  logic                 DnStrFull;
  logic                 GntDnStr;

  modport master (
    output PacketOut,
    output ReqDnStr,
    input  DnStrFull,
    input  GntDnStr
  );

  modport slave (
    input  PacketOut,
    input  ReqDnStr,
    output DnStrFull,
    output GntDnStr
  );
endinterface

`default_nettype wire

// File: rtl/traffic_injector.sv
// ============================================================================
// traffic_injector : paced packet source for a router Local input port
// Rev 1.0
// ============================================================================
`default_nettype none

module traffic_injector #(
  parameter logic [5:0] routerID    = 6'b000_000,
  parameter logic [5:0] ModuleID    = 6'b000_000,
  parameter int         dataWidth   = 32,
  parameter int         dim         = 4,
  parameter int         DEST_MODE   = 0,
  parameter logic [5:0] FIXED_DEST  = 6'b000_001,
  parameter int         GAP         = 4,
  parameter int         NUM_PACKETS = 16
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          Enable,
  traffic_injector_if.master dn,
  output logic [15:0]        PacketsSent,
  output logic               Done
);

  localparam int          c_GAP_W    = (GAP < 1) ? 1 : $clog2(GAP + 1);
  localparam logic [2:0]  c_LAST     = 3'(dim - 1);
  localparam logic [15:0] c_NUM      = 16'(NUM_PACKETS);
  localparam logic        c_NUM_EN   = (NUM_PACKETS > 0);
  localparam logic        c_HAS_PEER = (DEST_MODE == 0) || (dim > 1);

  // Walk the mesh x-major: y runs fastest, both wrap at dim-1.
  function automatic logic [5:0] f_step(input logic [5:0] n);
    logic [5:0] r;
    r = n;
    if (n[2:0] == c_LAST) begin
      r[2:0] = 3'd0;
      r[5:3] = (n[5:3] == c_LAST) ? 3'd0 : n[5:3] + 3'd1;
    end else begin
      r[2:0] = n[2:0] + 3'd1;
    end
    return r;
  endfunction

  function automatic logic [5:0] f_next(input logic [5:0] n);
    logic [5:0] r;
    r = f_step(n);
    if (r == routerID) r = f_step(r);
    return r;
  endfunction

  localparam logic [5:0] c_RR_FIRST = (routerID == 6'd0) ? f_step(6'd0) : 6'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [9:0]           r_pkt_id;
  logic [5:0]           r_rr;
  logic [c_GAP_W-1:0]   r_gap_cnt;
  logic [dataWidth-1:0] r_pkt;
  logic [15:0]          r_sent;
  logic                 r_done;
  logic                 w_start;
  logic                 w_grant;
  logic                 w_can_start;
  logic [5:0]           w_dest;
  logic [15:0]          w_sent_inc;
  logic [dataWidth-1:0] w_pkt;

  assign w_can_start = Enable && !r_done && !dn.DnStrFull && c_HAS_PEER;
  assign w_dest      = (DEST_MODE == 1) ? r_rr : FIXED_DEST;
  assign w_sent_inc  = (r_sent == 16'hFFFF) ? r_sent : r_sent + 16'd1;

  always_comb begin
    w_pkt       = '0;
    w_pkt[21:0] = {w_dest, r_pkt_id, ModuleID};
  end

  // The final gap cycle doubles as IDLE so Req stays low exactly GAP+1 cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_grant     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_can_start) begin
          w_start     = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (dn.GntDnStr) begin
          w_grant     = 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == '0) begin
          if (w_can_start) begin
            w_start     = 1'b1;
            w_state_nxt = S_REQ;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pkt     <= '0;
      r_pkt_id  <= '0;
      r_rr      <= c_RR_FIRST;
      r_gap_cnt <= '0;
      r_sent    <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) r_pkt <= w_pkt;
      if (w_grant) begin
        r_pkt_id  <= r_pkt_id + 10'd1;
        r_rr      <= f_next(r_rr);
        r_gap_cnt <= c_GAP_W'(GAP);
        r_sent    <= w_sent_inc;
        if (c_NUM_EN && (w_sent_inc == c_NUM)) r_done <= 1'b1;
      end else if ((r_state == S_GAP) && (r_gap_cnt != '0)) begin
        r_gap_cnt <= r_gap_cnt - c_GAP_W'(1);
      end
    end
  end

  assign dn.PacketOut = r_pkt;
  assign dn.ReqDnStr  = (r_state == S_REQ);
  assign PacketsSent  = r_sent;
  assign Done         = r_done;

endmodule

`default_nettype wire

// File: tb/tb_traffic_injector.sv
// ============================================================================
// tb_traffic_injector : four injector lanes against a behavioural packet model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_traffic_injector;

  logic clk        = 1'b0;
  logic reset      = 1'b1;
  bit   rnd_mode   = 1'b0;
  bit   force_full = 1'b1;
  int   vec        = 0;
  int   err        = 0;

  always #5 clk = ~clk;

  task automatic check(input string nm, input int lane,
                       input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s lane%0d: got %h, expected %h at %0t", nm, lane, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [5:0] RID  = (gi == 1) ? 6'o11 : 6'o00;
    localparam logic [5:0] MID  = (gi == 0) ? 6'h05 : (gi == 1) ? 6'h2A : (gi == 2) ? 6'h3F : 6'h11;
    localparam int         MODE = (gi == 0) ? 0 : 1;
    localparam int         DIM  = (gi == 3) ? 1 : 4;
    localparam int         LGAP = (gi == 0) ? 4 : (gi == 1) ? 2 : (gi == 2) ? 0 : 1;
    localparam int         NUM  = (gi == 2) ? 0 : (gi == 3) ? 4 : 16;
    localparam logic [5:0] FIX  = 6'o01;

    traffic_injector_if #(.dataWidth(32)) u_if ();
    logic        en;
    logic [15:0] sent;
    logic        done;

    traffic_injector #(
      .routerID(RID), .ModuleID(MID), .dataWidth(32), .dim(DIM),
      .DEST_MODE(MODE), .FIXED_DEST(FIX), .GAP(LGAP), .NUM_PACKETS(NUM)
    ) u_dut (
      .clk(clk), .reset(reset), .Enable(en), .dn(u_if),
      .PacketsSent(sent), .Done(done)
    );

    // Router side: grant after a (random) wait, occasional spurious grants.
    initial begin
      int hi;
      int dly;
      hi = 0;
      dly = 0;
      en = 1'b1;
      u_if.DnStrFull = 1'b1;
      u_if.GntDnStr  = 1'b0;
      forever begin
        @(posedge clk);
        #2;
        if (u_if.ReqDnStr) hi++; else hi = 0;
        if (hi == 1) dly = rnd_mode ? int'($urandom_range(0, 4)) : 0;
        if (!rnd_mode) begin
          en = 1'b1;
          u_if.DnStrFull = force_full;
          u_if.GntDnStr  = (hi == 2);
        end else begin
          en = ($urandom_range(0, 7) != 0);
          u_if.DnStrFull = ($urandom_range(0, 3) == 0);
          u_if.GntDnStr  = (hi != 0) ? (hi == dly + 2) : ($urandom_range(0, 7) == 0);
        end
      end
    end

    // Destinations in visiting order: every mesh node but our own router.
    logic [5:0] dest_tab [64];
    int         n_nodes;
    initial begin
      n_nodes = 0;
      for (int x = 0; x < DIM; x++)
        for (int y = 0; y < DIM; y++)
          if (6'(x * 8 + y) != RID) begin
            dest_tab[n_nodes] = 6'(x * 8 + y);
            n_nodes++;
          end
    end

    // Model: a request may start once GAP+1 low cycles have elapsed since the
    // last grant; each grant retires one packet.
    bit          m_req;
    logic [31:0] m_pkt;
    int          m_sent, m_id, m_k, m_low;
    bit          m_done;

    always @(posedge clk or posedge reset) begin
      if (reset) begin
        m_req  <= 1'b0;
        m_pkt  <= '0;
        m_sent <= 0;
        m_done <= 1'b0;
        m_id   <= 0;
        m_k    <= 0;
        m_low  <= LGAP + 1;
      end else if (m_req) begin
        if (u_if.GntDnStr) begin
          m_req <= 1'b0;
          m_low <= 0;
          if (m_sent < 65535) m_sent <= m_sent + 1;
          m_id <= (m_id + 1) % 1024;
          if (n_nodes > 0) m_k <= (m_k + 1) % n_nodes;
          if (NUM > 0 && m_sent + 1 == NUM) m_done <= 1'b1;
        end
      end else begin
        if (m_low < 100000) m_low <= m_low + 1;
        if ((m_low + 1 >= LGAP + 1) && en && !u_if.DnStrFull && !m_done &&
            (MODE == 0 || n_nodes > 0)) begin
          m_req <= 1'b1;
          m_pkt <= {10'd0, ((MODE == 0) ? FIX : dest_tab[m_k]), 10'(m_id), MID};
        end
      end
    end

    always @(negedge clk) begin
      if (!reset) begin
        check("req",  gi, {31'd0, u_if.ReqDnStr}, {31'd0, m_req});
        check("pkt",  gi, u_if.PacketOut, m_pkt);
        check("sent", gi, {16'd0, sent}, 32'(m_sent));
        check("done", gi, {31'd0, done}, {31'd0, m_done});
      end
    end
  end

  initial begin
    int          cyc;
    int          run;
    bit          anyreq;
    logic [31:0] tmp;

    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    @(negedge clk);
    check("rst_pkt",  0, g_lane[0].u_if.PacketOut, 32'h0);
    check("rst_req",  0, {31'd0, g_lane[0].u_if.ReqDnStr}, 32'd0);
    check("rst_sent", 0, {16'd0, g_lane[0].sent}, 32'd0);
    check("rst_done", 0, {31'd0, g_lane[0].done}, 32'd0);
    check("rr_count", 1, 32'(g_lane[1].n_nodes), 32'd15);
    check("rr_tab4",  1, {26'd0, g_lane[1].dest_tab[4]}, 32'o10);
    check("rr_tab5",  1, {26'd0, g_lane[1].dest_tab[5]}, 32'o12);

    anyreq = 1'b0;
    repeat (10) begin
      @(negedge clk);
      anyreq |= g_lane[0].u_if.ReqDnStr;
    end
    check("full_blocks_req", 0, {31'd0, anyreq}, 32'd0);

    force_full = 1'b0;
    cyc = 0;
    while (!g_lane[0].u_if.ReqDnStr && cyc < 20) begin @(negedge clk); cyc++; end
    check("first_pkt", 0, g_lane[0].u_if.PacketOut, 32'h0001_0005);
    for (int p = 0; p < 2; p++) begin
      run = 0;
      while (g_lane[0].u_if.ReqDnStr && run < 20) begin @(negedge clk); run++; end
      check("req_high_len", 0, 32'(run), 32'd2);
      run = 0;
      while (!g_lane[0].u_if.ReqDnStr && run < 20) begin @(negedge clk); run++; end
      check("req_low_len", 0, 32'(run), 32'd5);
      check("next_pkt", 0, g_lane[0].u_if.PacketOut,
            (p == 0) ? 32'h0001_0045 : 32'h0001_0085);
    end

    cyc = 0;
    while (!g_lane[0].done && cyc < 400) begin @(negedge clk); cyc++; end
    check("done_set",   0, {31'd0, g_lane[0].done}, 32'd1);
    check("sent_16",    0, {16'd0, g_lane[0].sent}, 32'd16);
    check("last_pkt",   0, g_lane[0].u_if.PacketOut, 32'h0001_03C5);
    check("rr_last",    1, g_lane[1].u_if.PacketOut, 32'h0000_03EA);
    anyreq = 1'b0;
    repeat (10) begin
      @(negedge clk);
      anyreq |= g_lane[0].u_if.ReqDnStr;
    end
    check("no_req_after_done", 0, {31'd0, anyreq}, 32'd0);

    rnd_mode = 1'b1;
    repeat (200) @(negedge clk);
    cyc = 0;
    while (!g_lane[2].u_if.ReqDnStr && cyc < 200) begin @(negedge clk); cyc++; end
    check("req_before_reset", 2, {31'd0, g_lane[2].u_if.ReqDnStr}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_req_drop", 2, {31'd0, g_lane[2].u_if.ReqDnStr}, 32'd0);
    check("async_sent_clr", 2, {16'd0, g_lane[2].sent}, 32'd0);
    check("async_done_clr", 0, {31'd0, g_lane[0].done}, 32'd0);
    @(negedge clk);
    #1 reset = 1'b0;

    cyc = 0;
    while (!g_lane[2].u_if.ReqDnStr && cyc < 200) begin @(negedge clk); cyc++; end
    tmp = g_lane[2].u_if.PacketOut;
    check("id_after_reset", 2, 32'(tmp[15:6]), 32'd0);

    cyc = 0;
    while (g_lane[2].sent < 16'd1100 && cyc < 20000) begin @(negedge clk); cyc++; end
    check("wrap_reached", 2, {31'd0, (g_lane[2].sent >= 16'd1100)}, 32'd1);
    check("dim1_silent",  3, {16'd0, g_lane[3].sent}, 32'd0);
    check("random_done",  0, {31'd0, g_lane[0].done}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

`default_nettype wire
